// File: rtl/knight_rider_shifter_if.sv
// Bundles the run controls and LED/status outputs of knight_rider_shifter.
// The master drives en, tick_in and mode; the slave (the shifter) drives the outputs.
interface knight_rider_shifter_if #(
  parameter int unsigned LED_WIDTH = 8
);
  localparam int unsigned PosW = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;

  logic                 en;
  logic                 tick_in;
  logic                 mode;
  logic [LED_WIDTH-1:0] led;
  logic [PosW-1:0]      pos;
  logic                 dir;
  logic                 sweep_done;

  modport master (
    output en,
    output tick_in,
    output mode,
    input  led,
    input  pos,
    input  dir,
    input  sweep_done
  );

  modport slave (
    input  en,
    input  tick_in,
    input  mode,
    output led,
    output pos,
    output dir,
    output sweep_done
  );
endinterface

// File: rtl/knight_rider_shifter.sv
// Single-LED sweeper advanced by rising edges of a slow tick; bounces or wraps across the bus.
// Optional KNIGHT_RIDER_TRAIL_EN also lights the previously occupied LED.
module knight_rider_shifter #(
  parameter int unsigned LED_WIDTH = 8,
  parameter int unsigned START_POS = 0
) (
  input logic                   clk,
  input logic                   rstn,
  knight_rider_shifter_if.slave bus
);

  localparam int unsigned PosW = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;
  localparam logic [PosW-1:0] TopPos   = PosW'(LED_WIDTH - 1);
  localparam logic [PosW-1:0] StartPos = PosW'(START_POS);
  localparam logic [PosW-1:0] OnePos   = PosW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StUp,
    StDown
  } state_e;

  state_e               state_q, state_d;
  logic [PosW-1:0]      pos_q, pos_d;
  logic                 dir_q, dir_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 sweep_q, sweep_d;
  logic                 tick_dly_q;
  logic                 tick;

`ifdef KNIGHT_RIDER_TRAIL_EN
  logic [PosW-1:0]      prev_q, prev_d;
`endif

  function automatic logic [LED_WIDTH-1:0] onehot(input logic [PosW-1:0] p);
    return LED_WIDTH'(1) << p;
  endfunction

  assign tick = bus.tick_in & ~tick_dly_q;

  // Direction flips on arrival at an end, so the end LED holds for exactly one tick period
  // and sweep_done fires on the tick that lands back on index 0.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    sweep_d = 1'b0;
`ifdef KNIGHT_RIDER_TRAIL_EN
    prev_d  = prev_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Resume in the held direction; a tick in the enabling cycle is dropped.
        if (bus.en) begin
          state_d = dir_q ? StDown : StUp;
`ifdef KNIGHT_RIDER_TRAIL_EN
          prev_d  = pos_q;
`endif
        end
      end

      StUp: begin
        if (!bus.en) begin
          state_d = StIdle;
        end else if (tick) begin
`ifdef KNIGHT_RIDER_TRAIL_EN
          prev_d = pos_q;
`endif
          if (pos_q == TopPos) begin
            if (LED_WIDTH == 1 || bus.mode) begin
              pos_d   = '0;
              sweep_d = 1'b1;
            end else begin
              // Parked at the top in wrap mode, then mode cleared: descend instead.
              pos_d   = pos_q - OnePos;
              state_d = StDown;
              dir_d   = 1'b1;
            end
          end else begin
            pos_d = pos_q + OnePos;
            if ((pos_q + OnePos == TopPos) && !bus.mode) begin
              state_d = StDown;
              dir_d   = 1'b1;
            end
          end
        end
      end

      StDown: begin
        if (!bus.en) begin
          state_d = StIdle;
        end else if (tick) begin
`ifdef KNIGHT_RIDER_TRAIL_EN
          prev_d = pos_q;
`endif
          if (pos_q == '0) begin
            pos_d   = pos_q + OnePos;
            state_d = StUp;
            dir_d   = 1'b0;
          end else begin
            pos_d = pos_q - OnePos;
            if (pos_q == OnePos) begin
              state_d = StUp;
              dir_d   = 1'b0;
              sweep_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d == StIdle) begin
      led_d = '0;
    end else begin
`ifdef KNIGHT_RIDER_TRAIL_EN
      led_d = onehot(pos_d) | onehot(prev_d);
`else
      led_d = onehot(pos_d);
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      pos_q      <= StartPos;
      dir_q      <= 1'b0;
      led_q      <= '0;
      sweep_q    <= 1'b0;
      tick_dly_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      led_q      <= led_d;
      sweep_q    <= sweep_d;
      tick_dly_q <= bus.tick_in;
    end
  end

`ifdef KNIGHT_RIDER_TRAIL_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= StartPos;
    end else begin
      prev_q <= prev_d;
    end
  end
`endif

  assign bus.led        = led_q;
  assign bus.pos        = pos_q;
  assign bus.dir        = dir_q;
  assign bus.sweep_done = sweep_q;

  a_idle_dark: assert property (@(posedge clk) disable iff (!rstn)
    (state_q == StIdle) |-> (led_q == '0 && !sweep_q));

`ifndef KNIGHT_RIDER_TRAIL_EN
  a_run_onehot: assert property (@(posedge clk) disable iff (!rstn)
    (state_q != StIdle) |-> $onehot(led_q));
`endif

endmodule

// File: tb/tb_knight_rider_shifter.sv
// Table-driven, scoreboarded bench for knight_rider_shifter (LED_WIDTH=8, START_POS=0).
module tb_knight_rider_shifter;

  localparam int unsigned W = 8;
`ifdef KNIGHT_RIDER_TRAIL_EN
  localparam bit Trail = 1'b1;
`else
  localparam bit Trail = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  knight_rider_shifter_if #(.LED_WIDTH(W)) bus ();

  knight_rider_shifter #(
    .LED_WIDTH(W),
    .START_POS(0)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic [7:0] led;
    logic [2:0] pos;
    logic       dir;
    logic       sweep;
  } exp_t;

  typedef struct {
    logic       mode;
    logic [2:0] pos;
    logic       dir;
    logic       sweep;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[$];
  int         total = 0;
  int         bad = 0;
  logic [2:0] last_pos;

  function automatic logic [7:0] led_of(input logic [2:0] p, input logic [2:0] prev);
    return (8'h01 << p) | (Trail ? (8'h01 << prev) : 8'h00);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] led, input logic [2:0] p, input logic d, input logic s);
    exp_t e;
    e.led   = led;
    e.pos   = p;
    e.dir   = d;
    e.sweep = s;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got 0 want 1 entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".led"},   32'(bus.led),        32'(e.led));
      check({tag, ".pos"},   32'(bus.pos),        32'(e.pos));
      check({tag, ".dir"},   32'(bus.dir),        32'(e.dir));
      check({tag, ".sweep"}, 32'(bus.sweep_done), 32'(e.sweep));
    end
  endtask

  task automatic add(input int m, input int p, input int d, input int s);
    vec_t v;
    v.mode  = m[0];
    v.pos   = p[2:0];
    v.dir   = d[0];
    v.sweep = s[0];
    vecs.push_back(v);
  endtask

  // One tick: raise tick_in for a cycle, compare the move, then confirm the pulse has ended.
  task automatic do_tick(input string tag, input logic [2:0] p, input logic d, input logic s);
    bus.tick_in = 1'b1;
    push(led_of(p, last_pos), p, d, s);
    last_pos = p;
    step();
    pop_check(tag);
    bus.tick_in = 1'b0;
    step();
    check({tag, ".sweep_low"}, 32'(bus.sweep_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    // Bounce from 0: up to 7 (dir flips on arrival), down to 0 with sweep, then 1.
    for (int i = 1; i <= 6; i++) add(0, i, 0, 0);
    add(0, 7, 1, 0);
    for (int i = 6; i >= 1; i--) add(0, i, 1, 0);
    add(0, 0, 0, 1);
    add(0, 1, 0, 0);
    // Wrap: stays upward, sweep on the wrap into 0.
    for (int i = 2; i <= 7; i++) add(1, i, 0, 0);
    add(1, 0, 0, 1);
    add(1, 1, 0, 0);
    // Back to bounce, stop on the way down at 5.
    for (int i = 2; i <= 6; i++) add(0, i, 0, 0);
    add(0, 7, 1, 0);
    add(0, 6, 1, 0);
    add(0, 5, 1, 0);

    rstn        = 1'b0;
    bus.en      = 1'b1;
    bus.tick_in = 1'b1;
    bus.mode    = 1'b0;
    last_pos    = 3'd0;

    #12;
    push(8'h00, 3'd0, 1'b0, 1'b0);
    pop_check("reset");

    @(negedge clk);
    rstn = 1'b1;
    step();
    push(led_of(3'd0, 3'd0), 3'd0, 1'b0, 1'b0);
    pop_check("entry");
    step();
    push(led_of(3'd0, 3'd0), 3'd0, 1'b0, 1'b0);
    pop_check("high_at_release");
    bus.tick_in = 1'b0;
    step();
    push(led_of(3'd0, 3'd0), 3'd0, 1'b0, 1'b0);
    pop_check("tick_low");

    foreach (vecs[i]) begin
      bus.mode = vecs[i].mode;
      do_tick($sformatf("vec%0d", i), vecs[i].pos, vecs[i].dir, vecs[i].sweep);
    end

    // Disable at pos 5 going down; ticks while idle must not move.
    bus.en = 1'b0;
    step();
    push(8'h00, 3'd5, 1'b1, 1'b0);
    pop_check("idle");
    bus.tick_in = 1'b1;
    step();
    push(8'h00, 3'd5, 1'b1, 1'b0);
    pop_check("idle_tick");
    bus.tick_in = 1'b0;
    step();
    bus.en = 1'b1;
    step();
    last_pos = 3'd5;
    push(led_of(3'd5, 3'd5), 3'd5, 1'b1, 1'b0);
    pop_check("resume");
    do_tick("resume_tick", 3'd4, 1'b1, 1'b0);

    // Enable rising together with a tick edge: tick dropped.
    bus.en = 1'b0;
    step();
    bus.en      = 1'b1;
    bus.tick_in = 1'b1;
    step();
    last_pos = 3'd4;
    push(led_of(3'd4, 3'd4), 3'd4, 1'b1, 1'b0);
    pop_check("en_with_tick");
    bus.tick_in = 1'b0;
    step();
    push(led_of(3'd4, 3'd4), 3'd4, 1'b1, 1'b0);
    pop_check("en_with_tick_hold");
    do_tick("to_pos3", 3'd3, 1'b1, 1'b0);

    // Asynchronous reset between clock edges.
    #2;
    rstn = 1'b0;
    #1;
    push(8'h00, 3'd0, 1'b0, 1'b0);
    pop_check("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    step();
    last_pos = 3'd0;
    push(led_of(3'd0, 3'd0), 3'd0, 1'b0, 1'b0);
    pop_check("post_rst_entry");
    step();
    do_tick("post_rst_tick", 3'd1, 1'b0, 1'b0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
